// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue stage: ALU select codes, MIPS
// opcode/funct values, decode side-band enums and the issue-entry record.
package alu_pkg;

    localparam int ALU_WIDTH  = 32;
    localparam int ALU_REG_AW = 5;

    // ALU select codes
    localparam logic [2:0] SEL_NOT = 3'b000;
    localparam logic [2:0] SEL_AND = 3'b001;
    localparam logic [2:0] SEL_XOR = 3'b010;
    localparam logic [2:0] SEL_OR  = 3'b011;
    localparam logic [2:0] SEL_DEC = 3'b100;
    localparam logic [2:0] SEL_ADD = 3'b101;
    localparam logic [2:0] SEL_SUB = 3'b110;
    localparam logic [2:0] SEL_INC = 3'b111;

    // MIPS opcodes
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;

    // MIPS R-type funct codes (0x30..0x32 are local extensions for INC/DEC/NOT)
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_INC  = 6'h30;
    localparam logic [5:0] FN_DEC  = 6'h31;
    localparam logic [5:0] FN_NOT  = 6'h32;

    // Source of operand b
    typedef enum logic [1:0] {
        IMM_NONE = 2'd0,   // b is the (forwarded) rt value
        IMM_SEXT = 2'd1,   // b is the sign-extended immediate
        IMM_ZEXT = 2'd2    // b is the zero-extended immediate
    } imm_mode_e;

    // Destination register select
    typedef enum logic [1:0] {
        DEST_ZERO = 2'd0,
        DEST_RD   = 2'd1,
        DEST_RT   = 2'd2
    } dest_e;

    // One entry held by the issue stage (output register or skid slot)
    typedef struct packed {
        logic [ALU_WIDTH-1:0]  a;
        logic [ALU_WIDTH-1:0]  b;
        logic [2:0]            sel;
        logic [ALU_REG_AW-1:0] wr_rd;
        logic                  ovf_trap;
        logic                  illegal;
    } issue_entry_t;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational MIPS opcode/funct decode into ALU select, operand-b source,
// destination select, overflow-trap and illegal flags.
module alu_op_decode
    import alu_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output logic [2:0] sel,
    output imm_mode_e  imm_mode,
    output dest_e      dest,
    output logic       ovf_trap,
    output logic       illegal
);

    // Table decode; unsupported codes fall back to NOT with no destination
    always_comb begin
        sel      = SEL_NOT;
        imm_mode = IMM_NONE;
        dest     = DEST_ZERO;
        ovf_trap = 1'b0;
        illegal  = 1'b0;
        if (opcode == OP_RTYPE) begin
            dest = DEST_RD;
            case (funct)
                FN_ADD:  begin sel = SEL_ADD; ovf_trap = 1'b1; end
                FN_ADDU: sel = SEL_ADD;
                FN_SUB:  begin sel = SEL_SUB; ovf_trap = 1'b1; end
                FN_SUBU: sel = SEL_SUB;
                FN_AND:  sel = SEL_AND;
                FN_OR:   sel = SEL_OR;
                FN_XOR:  sel = SEL_XOR;
                FN_INC:  sel = SEL_INC;
                FN_DEC:  sel = SEL_DEC;
                FN_NOT:  sel = SEL_NOT;
                default: begin
                    illegal = 1'b1;
                    dest    = DEST_ZERO;
                end
            endcase
        end else begin
            case (opcode)
                OP_ADDI: begin
                    sel = SEL_ADD; imm_mode = IMM_SEXT; dest = DEST_RT; ovf_trap = 1'b1;
                end
                OP_ADDIU: begin
                    sel = SEL_ADD; imm_mode = IMM_SEXT; dest = DEST_RT;
                end
                OP_ANDI: begin
                    sel = SEL_AND; imm_mode = IMM_ZEXT; dest = DEST_RT;
                end
                OP_ORI: begin
                    sel = SEL_OR; imm_mode = IMM_ZEXT; dest = DEST_RT;
                end
                OP_XORI: begin
                    sel = SEL_XOR; imm_mode = IMM_ZEXT; dest = DEST_RT;
                end
                OP_BEQ: begin
                    sel = SEL_SUB;
                end
                default: begin
                    illegal = 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/alu_issue_stage.sv
// ALU issue stage: operand forwarding, immediate selection and op decode,
// registered behind a 2-entry skid buffer (output register + one skid slot).
// Optional macro ALU_ISSUE_PERF_EN adds a saturating output-stall counter.
//
// Handshake: a transfer happens on a cycle where valid && ready are both high
// at the rising edge. in_ready is the inverse of the skid-slot occupancy
// flop, so it never depends combinationally on out_ready. While
// out_valid && !out_ready, every out_* signal holds its value.
module alu_issue_stage
    import alu_pkg::*;
#(
    // Must match ALU_WIDTH / ALU_REG_AW, which size the stored entry record
    parameter int WIDTH  = ALU_WIDTH,
    parameter int REG_AW = ALU_REG_AW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [5:0]        in_opcode,
    input  logic [5:0]        in_funct,
    input  logic [REG_AW-1:0] in_rs,
    input  logic [REG_AW-1:0] in_rt,
    input  logic [REG_AW-1:0] in_rd,
    input  logic [WIDTH-1:0]  in_rs_data,
    input  logic [WIDTH-1:0]  in_rt_data,
    input  logic [15:0]       in_imm,
    input  logic              fwd_exmem_valid,
    input  logic              fwd_memwb_valid,
    input  logic [REG_AW-1:0] fwd_exmem_rd,
    input  logic [REG_AW-1:0] fwd_memwb_rd,
    input  logic [WIDTH-1:0]  fwd_exmem_data,
    input  logic [WIDTH-1:0]  fwd_memwb_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_a,
    output logic [WIDTH-1:0]  out_b,
    output logic [2:0]        out_sel,
    output logic [REG_AW-1:0] out_wr_rd,
    output logic              out_ovf_trap,
    output logic              out_illegal
`ifdef ALU_ISSUE_PERF_EN
    ,
    output logic [31:0]       perf_stall_cnt
`endif
);

    // Index 0 reads as zero; EX/MEM beats MEM/WB beats register file
    function automatic logic [WIDTH-1:0] fwd_operand(
        input logic [REG_AW-1:0] idx,
        input logic [WIDTH-1:0]  rf_data,
        input logic              ex_v,
        input logic [REG_AW-1:0] ex_rd,
        input logic [WIDTH-1:0]  ex_data,
        input logic              wb_v,
        input logic [REG_AW-1:0] wb_rd,
        input logic [WIDTH-1:0]  wb_data
    );
        logic [WIDTH-1:0] r;
        if (idx == '0)                      r = '0;
        else if (ex_v && (ex_rd == idx))    r = ex_data;
        else if (wb_v && (wb_rd == idx))    r = wb_data;
        else                                r = rf_data;
        return r;
    endfunction

    logic [2:0]       dec_sel;
    imm_mode_e        dec_imm_mode;
    dest_e            dec_dest;
    logic             dec_ovf_trap;
    logic             dec_illegal;

    logic [WIDTH-1:0] rs_val;
    logic [WIDTH-1:0] rt_val;
    issue_entry_t     new_e;

    issue_entry_t     out_e;
    logic             out_vld;
    issue_entry_t     skid_e;
    logic             skid_vld;

    logic             accept;
    logic             out_free;

    alu_op_decode u_decode (
        .opcode   (in_opcode),
        .funct    (in_funct),
        .sel      (dec_sel),
        .imm_mode (dec_imm_mode),
        .dest     (dec_dest),
        .ovf_trap (dec_ovf_trap),
        .illegal  (dec_illegal)
    );

    // Build the entry that would be captured this cycle (forwarding sampled here only)
    always_comb begin
        rs_val = fwd_operand(in_rs, in_rs_data, fwd_exmem_valid, fwd_exmem_rd, fwd_exmem_data,
                             fwd_memwb_valid, fwd_memwb_rd, fwd_memwb_data);
        rt_val = fwd_operand(in_rt, in_rt_data, fwd_exmem_valid, fwd_exmem_rd, fwd_exmem_data,
                             fwd_memwb_valid, fwd_memwb_rd, fwd_memwb_data);
        new_e          = '0;
        new_e.a        = rs_val;
        new_e.sel      = dec_sel;
        new_e.ovf_trap = dec_ovf_trap;
        new_e.illegal  = dec_illegal;
        case (dec_imm_mode)
            IMM_SEXT: new_e.b = {{(WIDTH-16){in_imm[15]}}, in_imm};
            IMM_ZEXT: new_e.b = {{(WIDTH-16){1'b0}}, in_imm};
            default:  new_e.b = rt_val;
        endcase
        case (dec_dest)
            DEST_RD: new_e.wr_rd = in_rd;
            DEST_RT: new_e.wr_rd = in_rt;
            default: new_e.wr_rd = '0;
        endcase
    end

    assign in_ready = !skid_vld;
    assign accept   = in_valid && in_ready && !flush;
    // Output register can take a new value: empty, or its entry leaves this cycle
    assign out_free = !out_vld || out_ready;

    // Output register and skid slot; skid is only ever occupied behind a full output
    always_ff @(posedge clk) begin
        if (rst) begin
            out_e    <= '0;
            out_vld  <= 1'b0;
            skid_e   <= '0;
            skid_vld <= 1'b0;
        end else if (flush) begin
            out_vld  <= 1'b0;
            skid_vld <= 1'b0;
        end else if (out_free) begin
            if (skid_vld) begin
                out_e    <= skid_e;
                out_vld  <= 1'b1;
                skid_vld <= 1'b0;
            end else begin
                out_vld <= accept;
                if (accept) out_e <= new_e;
            end
        end else if (accept) begin
            skid_e   <= new_e;
            skid_vld <= 1'b1;
        end
    end

    assign out_valid    = out_vld;
    assign out_a        = out_e.a;
    assign out_b        = out_e.b;
    assign out_sel      = out_e.sel;
    assign out_wr_rd    = out_e.wr_rd;
    assign out_ovf_trap = out_e.ovf_trap;
    assign out_illegal  = out_e.illegal;

`ifdef ALU_ISSUE_PERF_EN
    // Count cycles where the ALU side holds a valid entry it cannot pass on
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_cnt <= '0;
        end else if (out_vld && !out_ready && (perf_stall_cnt != 32'hFFFF_FFFF)) begin
            perf_stall_cnt <= perf_stall_cnt + 32'd1;
        end
    end
`endif

endmodule
